truth_table_sweeper: RTL

Sequential stimulus-and-capture stage for the 4-input combinational lab circuits. It drives every input vector onto the circuit under test in ascending order and waits a programmable settle time per vector. It samples the circuit output `f` into a truth-table register and compares that output against an expected table. The block replaces hand-written stimulus lists: the combinational circuit's inputs connect directly to `vec`, and its output connects to `f`.

---
 rtl/truth_table_sweeper_pkg.sv | 16 +
 rtl/truth_table_sweeper_settle_counter.sv | 26 ++
 rtl/truth_table_sweeper.sv | 111 +++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// settle-counter width and the default expected table.
package truth_table_sweeper_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int CNT_W = 8;

    localparam logic [15:0] EXPECTED_DEFAULT = 16'h0000;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle-time down-counter: loads on request, counts down to zero and holds there.
module settle_counter
    import truth_table_sweeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a small combinational circuit, captures its
// output into a truth table and counts mismatches against an expected table.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | after reset, waiting for start
//   ST_SETTLE | vec applied, waiting for the circuit output to settle
//   ST_SAMPLE | one cycle: capture f, compare, advance or finish
//   ST_DONE   | results held until the next start
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int                  N_IN          = 4,
    parameter int                  SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED      = EXPECTED_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_IN-1:0]     vec,
    input  logic                f,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  table_out,
    output logic [N_IN:0]       err_count,
    output logic                first_err_valid,
    output logic [N_IN-1:0]     first_err_idx,
    output logic                pass
);

    localparam int               N_VEC       = 2**N_IN;
    localparam logic [N_IN-1:0]  LAST_VEC    = N_IN'(N_VEC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t state;
    state_t state_nx;
    logic   accept;
    logic   sample_en;
    logic   cnt_load;
    logic   cnt_zero;
    logic   last_vec;
    logic   mismatch;

    settle_counter u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nx = ST_SETTLE;
            ST_SETTLE:        if (cnt_zero) state_nx = ST_SAMPLE;
            ST_SAMPLE:        state_nx = last_vec ? ST_DONE : ST_SETTLE;
            default:          state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
        done      = (state == ST_DONE);
        accept    = ((state == ST_IDLE) || (state == ST_DONE)) && start;
        sample_en = (state == ST_SAMPLE);
        cnt_load  = accept || (sample_en && !last_vec);
    end

    assign last_vec = (vec == LAST_VEC);
    // Case inequality so an undriven or unknown f is scored as a failure.
    assign mismatch = (f !== EXPECTED[vec]);
    assign pass     = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec             <= '0;
            table_out       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (accept) begin
            vec             <= '0;
            table_out       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (sample_en) begin
            table_out[vec] <= f;
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= vec;
                end
            end
            if (!last_vec) begin
                vec <= vec + 1'b1;
            end
        end
    end

endmodule
